mulu: RTL
=========

MULU -- requirements
Module: mulu

Interface
REQ-001 Parameter WIDTH, default 8, total operand/result width (integer+fraction); SHALL satisfy WIDTH >= 2.
REQ-002 Parameter FBITS, default 4, fractional bits of operands and result; SHALL satisfy 0 <= FBITS < WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  start pulse; accepted only when busy=0.
REQ-006 a  input  WIDTH  multiplicand, unsigned Q(WIDTH-FBITS.FBITS).
REQ-007 b  input  WIDTH  multiplier, unsigned Q(WIDTH-FBITS.FBITS).
REQ-008 busy  output  1  multiplication in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 valid  output  1  val holds a completed result.
REQ-011 ovf  output  1  result exceeded WIDTH bits and was saturated; latched with valid.
REQ-012 val  output  WIDTH  product, unsigned Q(WIDTH-FBITS.FBITS).

Function
REQ-013 States SHALL be IDLE (busy=0) and RUN (busy=1); no other states.
REQ-014 IDLE: on an edge with start=1, the block SHALL latch a and b, clear the 2*WIDTH-bit product accumulator, set counter to 0, clear valid and ovf, and enter RUN.
REQ-015 start while busy=1 SHALL be ignored; latched operands SHALL NOT change.
REQ-016 Changes on a/b after acceptance SHALL NOT affect the result.
REQ-017 RUN: one shift-add iteration per clock, LSB-first over latched b: if the current b bit is 1, add latched a to the accumulator upper half (WIDTH+1-bit add incl. carry), then shift the accumulator right by one.
REQ-018 Exactly WIDTH iterations SHALL occur; counter SHALL run 0..WIDTH-1 without wrap.
REQ-019 On the edge of iteration WIDTH-1 the block SHALL return to IDLE: busy=0, done=1 for exactly one cycle, valid=1.
REQ-020 Latency: start accepted at edge E0 -> done high after edge E0+WIDTH; busy high for exactly WIDTH cycles.
REQ-021 Full product P = a*b (2*WIDTH bits); result SHALL be P[FBITS +: WIDTH] (truncation, no rounding).
REQ-022 If any bit of P[2*WIDTH-1 : WIDTH+FBITS] is 1, val SHALL be all-ones and ovf=1; otherwise ovf=0.
REQ-023 val, valid and ovf SHALL hold until the next accepted start or reset.
REQ-024 start=1 in the cycle done=1 SHALL be accepted (busy already 0); that edge clears done and valid.
REQ-025 No zero-operand fast path: a=0 or b=0 SHALL take the full WIDTH-cycle latency.

Reset
REQ-026 rst=1 SHALL immediately force busy=0, done=0, valid=0, ovf=0, val=0, with operand latches, accumulator and counter cleared, in state IDLE.
REQ-027 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow its release.
REQ-028 The first edge after rst deasserts SHALL accept start normally.

Structure
REQ-029 The state enum (IDLE, RUN) and default WIDTH/FBITS constants SHALL live in the shared fixed-point package used by the arithmetic units.
REQ-030 Single module, no sub-modules; iteration counter width SHALL be $clog2(WIDTH)+1 bits.

Verification (WIDTH=8, FBITS=4)
REQ-031 a=0x18 (1.5), b=0x20 (2.0), start -> done exactly 8 cycles later, val=0x30, ovf=0, valid=1.
REQ-032 a=0x40, b=0x3F -> val=0xFC, ovf=0; then a=0x40, b=0x40 -> val=0xFF, ovf=1; a=0xFF, b=0xFF -> val=0xFF, ovf=1.
REQ-033 a=0x01, b=0x01 -> val=0x00, ovf=0 (truncation); a=0x00, b=0x7F -> val=0x00 after full 8-cycle latency.
REQ-034 start with a=0x18, b=0x20; 3 cycles later pulse start with a=0xFF, b=0xFF -> ignored, result val=0x30, ovf=0.
REQ-035 rst asserted 4 cycles into RUN -> all outputs 0 immediately, no done; subsequent a=0x20, b=0x20 -> val=0x40.
REQ-036 start held high continuously with a=0x10, b=0x10 -> back-to-back operations, done every 9 cycles, val=0x10 each time.

Source files
------------

// File: rtl/mulu_pkg.sv
// Shared fixed-point package: controller state encoding and default Q-format
// geometry used by the arithmetic units.
package mulu_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_FBITS = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mulu_state_e;

endpackage

// File: rtl/mulu.sv
// Unsigned fixed-point sequential multiplier: one shift-add step per clock,
// LSB-first over the latched multiplier, with saturating truncated result.
module mulu
  import mulu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FBITS = DEF_FBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             ovf,
  output logic [WIDTH-1:0] val
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mulu_state_e        state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic               done_r;
  logic               valid_r;
  logic               ovf_r;
  logic [WIDTH-1:0]   val_r;

  logic [WIDTH:0]     addend_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   lo_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic               ovf_s;
  logic [WIDTH-1:0]   res_s;

  // One shift-add step plus the saturated result view of the stepped accumulator.
  always_comb begin
    addend_s = {(WIDTH + 1){1'b0}};
    if (b_r[cnt_r[IW-1:0]]) begin
      addend_s = {1'b0, a_r};
    end else begin
      addend_s = {(WIDTH + 1){1'b0}};
    end
    sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + addend_s;
    lo_s  = acc_r[WIDTH-1:0] >> 1;
    // The carry-extended sum lands one bit down; the lower half slides right under it.
    acc_next_s = {sum_s, {(WIDTH - 1){1'b0}}} | {{WIDTH{1'b0}}, lo_s};
    ovf_s = |(acc_next_s >> (WIDTH + FBITS));
    if (ovf_s) begin
      res_s = {WIDTH{1'b1}};
    end else begin
      res_s = acc_next_s[FBITS +: WIDTH];
    end
  end

  // Controller and datapath registers; every output is driven from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {(2 * WIDTH){1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
      val_r   <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            acc_r   <= {(2 * WIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          if (cnt_r == LAST_CNT) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            valid_r <= 1'b1;
            ovf_r   <= ovf_s;
            val_r   <= res_s;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign valid = valid_r;
  assign ovf   = ovf_r;
  assign val   = val_r;

endmodule
